// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main control FSM of the multicycle ARM datapath.
// Sequences fetch/decode/execute/writeback and emits strobes ahead of the CondEx gating.
module multicycle_ctrl_fsm #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic [1:0] FlagW,
    output logic       Illegal
);
    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, UNKNOWN
    } state_t;
    state_t     state_q, state_d;
    logic       nowrite_q, nowrite_d;
    logic       irw, npc, regw, memw, branch, illegal, alu_op;
    logic [1:0] alu_ctl, flagw;
    logic       known, addsub, cmp;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            nowrite_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nowrite_q <= nowrite_d;
        end
    end
    always_comb begin
        cmp     = Funct[4:1] == 4'b1010;
        addsub  = Funct[4:1] == 4'b0100 || Funct[4:1] == 4'b0010 || cmp;
        known   = addsub || Funct[4:1] == 4'b0000 || Funct[4:1] == 4'b1100;
        alu_ctl = (Funct[4:1] == 4'b0010 || cmp) ? 2'b01 :
                  Funct[4:1] == 4'b0000 ? 2'b10 :
                  Funct[4:1] == 4'b1100 ? 2'b11 : 2'b00;
        flagw   = {Funct[0] & known, Funct[0] & addsub};
    end
    always_comb begin
        state_d    = FETCH;
        nowrite_d  = nowrite_q;
        irw        = 1'b0;
        npc        = 1'b0;
        regw       = 1'b0;
        memw       = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        alu_op     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        case (state_q)
            FETCH: begin
                state_d   = DECODE;
                irw       = 1'b1;
                npc       = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                state_d   = Op == 2'b01 ? MEMADR :
                            Op == 2'b00 ? (Funct[5] ? EXECI : EXECR) :
                            Op == 2'b10 ? BRANCH : UNKNOWN;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                state_d = Funct[0] ? MEMREAD : MEMWRITE;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                state_d = MEMWB;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
            end
            EXECR, EXECI: begin
                state_d   = ALUWB;
                alu_op    = 1'b1;
                ALUSrcB   = state_q == EXECI ? 2'b01 : 2'b00;
                nowrite_d = cmp;
            end
            ALUWB: regw = ~nowrite_q;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            UNKNOWN: illegal = 1'b1;
            default: state_d = FETCH;
        endcase
    end
    // Strobes are forced low while reset is held; selects keep their FETCH decode.
    assign ALUControl = alu_op ? alu_ctl : 2'b00;
    assign FlagW      = (alu_op && reset) ? flagw : 2'b00;
    assign IRWrite    = irw & reset;
    assign NextPC     = npc & reset;
    assign RegW       = regw & reset;
    assign MemW       = memw & reset;
    assign PCS        = (branch | (regw & Rd == 4'd15)) & reset;
    assign Illegal    = illegal & reset;
endmodule
